// File: rtl/button_mode_ctrl.sv
// Debounced 2-bit mode register: synchronizes {Q2,Q1}, commits a code after STABLE_CYCLES stable samples.
// Commit lands STABLE_CYCLES+2 edges after an input change; no backpressure, all outputs registered.
module button_mode_ctrl #(
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Q1,
    input  logic       Q2,
    output logic [1:0] mode,
    output logic [1:0] mode_prev,
    output logic       mode_changed,
    output logic       idle,
    output logic [7:0] change_count
);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    localparam logic [8:0]  STABLE_W  = 9'(STABLE_CYCLES);
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  sync1_q, sync1_d;
    logic [1:0]  sync2_q, sync2_d;
    logic [1:0]  cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  mode_prev_q, mode_prev_d;
    logic        mode_changed_q, mode_changed_d;
    logic        idle_q, idle_d;
    logic [7:0]  change_count_q, change_count_d;
    logic        commit;
    logic [8:0]  cnt_inc;

    always_comb begin
        sync1_d        = {Q2, Q1};
        sync2_d        = sync1_q;
        state_d        = state_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        commit         = 1'b0;
        cnt_inc        = {1'b0, cnt_q} + 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (sync2_q != mode_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sync2_q;
                    cnt_d   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (sync2_q == cand_q) begin
                    if (cnt_inc >= STABLE_W) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (sync2_q == mode_q) begin
                    // Input bounced back to the committed code: drop the candidate silently.
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cand_d = sync2_q;
                    cnt_d  = 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mode_d         = commit ? cand_q : mode_q;
        mode_prev_d    = commit ? mode_q : mode_prev_q;
        mode_changed_d = commit;
        change_count_d = (commit && change_count_q != 8'hFF) ? change_count_q + 8'd1 : change_count_q;

        if (commit)
            idle_cnt_d = 16'd0;
        else if (idle_cnt_q != 16'hFFFF)
            idle_cnt_d = idle_cnt_q + 16'd1;
        else
            idle_cnt_d = idle_cnt_q;
        // Compare against the next count so idle tracks idle_cnt in the same cycle.
        idle_d = ({1'b0, idle_cnt_d} >= TIMEOUT_W);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            sync1_q        <= 2'd0;
            sync2_q        <= 2'd0;
            cand_q         <= 2'd0;
            cnt_q          <= 8'd0;
            idle_cnt_q     <= 16'd0;
            mode_q         <= 2'd0;
            mode_prev_q    <= 2'd0;
            mode_changed_q <= 1'b0;
            idle_q         <= 1'b0;
            change_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            mode_q         <= mode_d;
            mode_prev_q    <= mode_prev_d;
            mode_changed_q <= mode_changed_d;
            idle_q         <= idle_d;
            change_count_q <= change_count_d;
        end
    end

    assign mode         = mode_q;
    assign mode_prev    = mode_prev_q;
    assign mode_changed = mode_changed_q;
    assign idle         = idle_q;
    assign change_count = change_count_q;

endmodule
